// File: rtl/mem_arb_pkg.sv
// Shared types and width helpers for the round-robin memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/memory_arbiter_rr_if.sv
// Client and memory-side bundle of memory_arbiter_rr.
// grant_cnt_o exists only when ARB_STATS_EN is defined.
interface memory_arbiter_rr_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
`ifdef ARB_STATS_EN
    , parameter int CNT_W = 16
`endif
);
    logic [NUM_REQ-1:0]        req_i;
    logic [NUM_REQ-1:0]        wen_i;
    logic [NUM_REQ*ADDR_W-1:0] addr_i;
    logic [NUM_REQ*DATA_W-1:0] wdata_i;
    logic [NUM_REQ-1:0]        done_o;
    logic [DATA_W-1:0]         rdata_o;
    logic                      busy_o;
    logic                      ram_ren_o;
    logic                      ram_wen_o;
    logic [ADDR_W-1:0]         ram_addr_o;
    logic [DATA_W-1:0]         ram_store_o;
    logic [DATA_W-1:0]         ram_load_i;
    logic                      ram_busy_i;
    logic                      tb_ctrl_i;
`ifdef ARB_STATS_EN
    logic [NUM_REQ*CNT_W-1:0]  grant_cnt_o;

    modport slave (
        input  req_i, wen_i, addr_i, wdata_i,
        input  ram_load_i, ram_busy_i, tb_ctrl_i,
        output done_o, rdata_o, busy_o,
        output ram_ren_o, ram_wen_o,
        output ram_addr_o, ram_store_o,
        output grant_cnt_o
    );

    modport master (
        output req_i, wen_i, addr_i, wdata_i,
        output ram_load_i, ram_busy_i, tb_ctrl_i,
        input  done_o, rdata_o, busy_o,
        input  ram_ren_o, ram_wen_o,
        input  ram_addr_o, ram_store_o,
        input  grant_cnt_o
    );
`else
    modport slave (
        input  req_i, wen_i, addr_i, wdata_i,
        input  ram_load_i, ram_busy_i, tb_ctrl_i,
        output done_o, rdata_o, busy_o,
        output ram_ren_o, ram_wen_o,
        output ram_addr_o, ram_store_o
    );

    modport master (
        output req_i, wen_i, addr_i, wdata_i,
        output ram_load_i, ram_busy_i, tb_ctrl_i,
        input  done_o, rdata_o, busy_o,
        input  ram_ren_o, ram_wen_o,
        input  ram_addr_o, ram_store_o
    );
`endif

endinterface

// File: rtl/memory_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request
// at or above ptr_i, wrapping past the top channel.
module rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               valid_o,
    output logic [IDX_W-1:0]   idx_o
);

    int k;

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        k       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = int'(ptr_i) + i;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            if (!valid_o && req_i[k[IDX_W-1:0]]) begin
                valid_o = 1'b1;
                idx_o   = k[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/memory_arbiter_rr.sv
// N-channel round-robin arbiter in front of single-ported main memory.
// Define ARB_STATS_EN to add saturating per-channel grant counters.
module memory_arbiter_rr
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
`ifdef ARB_STATS_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic                CLK,
    input  logic                RST,
    memory_arbiter_rr_if.slave  bus
);

    localparam int IDX_W = idx_w(NUM_REQ);
    typedef logic [IDX_W-1:0] idx_t;

    arb_state_t        state_q, state_d;
    idx_t              ptr_q, ptr_d;
    idx_t              idx_q, idx_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              pick_vld;
    idx_t              pick_idx;
    logic [ADDR_W-1:0] addr_a  [NUM_REQ];
    logic [DATA_W-1:0] wdata_a [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_a[g]  = bus.addr_i[g*ADDR_W +: ADDR_W];
        assign wdata_a[g] = bus.wdata_i[g*DATA_W +: DATA_W];
    end

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i   (bus.req_i),
        .ptr_i   (ptr_q),
        .valid_o (pick_vld),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (!bus.tb_ctrl_i && pick_vld) begin
                    idx_d   = pick_idx;
                    wen_d   = bus.wen_i[pick_idx];
                    addr_d  = addr_a[pick_idx];
                    wdata_d = wdata_a[pick_idx];
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!bus.ram_busy_i) begin
                    rdata_d = wen_q ? '0 : bus.ram_load_i;
                    state_d = RESP;
                end
            end
            RESP: begin
                ptr_d   = (idx_q == idx_t'(NUM_REQ-1)) ? '0
                                                       : idx_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Memory strobes are decoded from state so they vanish on abandon.
    always_comb begin
        bus.done_o      = '0;
        bus.rdata_o     = '0;
        bus.busy_o      = (state_q != IDLE);
        bus.ram_ren_o   = 1'b0;
        bus.ram_wen_o   = 1'b0;
        bus.ram_addr_o  = '0;
        bus.ram_store_o = '0;
        if (state_q == ACCESS) begin
            bus.ram_ren_o   = ~wen_q;
            bus.ram_wen_o   = wen_q;
            bus.ram_addr_o  = addr_q;
            bus.ram_store_o = wdata_q;
        end
        if (state_q == RESP) begin
            bus.done_o[idx_q] = 1'b1;
            bus.rdata_o       = rdata_q;
        end
    end

`ifdef ARB_STATS_EN
    logic [CNT_W-1:0] cnt_q [NUM_REQ];
    logic [CNT_W-1:0] cnt_d [NUM_REQ];

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == RESP && cnt_q[idx_q] != '1)
            cnt_d[idx_q] = cnt_q[idx_q] + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        assign bus.grant_cnt_o[g*CNT_W +: CNT_W] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_memory_arbiter_rr.sv
// Directed bench for memory_arbiter_rr with a completion scoreboard.
module tb_memory_arbiter_rr;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    memory_arbiter_rr_if #(
        .NUM_REQ (3),
        .ADDR_W  (32),
        .DATA_W  (32)
`ifdef ARB_STATS_EN
        , .CNT_W (16)
`endif
    ) bus ();

    memory_arbiter_rr #(
        .NUM_REQ (3),
        .ADDR_W  (32),
        .DATA_W  (32)
`ifdef ARB_STATS_EN
        , .CNT_W (16)
`endif
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    typedef struct {
        int          ch;
        bit          wr;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'h40) ? 32'hDEAD_BEEF : {a[15:0], ~a[15:0]};
    endfunction

    always_comb bus.ram_load_i = mem(bus.ram_addr_o);

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_addr(input int ch, input logic [31:0] a);
        bus.addr_i[ch*32 +: 32] = a;
    endtask

    always @(negedge clk) begin
        if (bus.done_o !== 3'b000) begin
            if (sb.size() == 0) begin
                chk("done_unexp", 64'(bus.done_o), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_ch", 64'(bus.done_o), 64'd1 << e.ch);
                if (!e.wr)
                    chk("rdata", 64'(bus.rdata_o), 64'(e.rdata));
            end
        end
    end

    task automatic do_read(input int ch, input logic [31:0] a);
        bit seen;
        set_addr(ch, a);
        bus.wen_i  = '0;
        bus.req_i  = 3'(1 << ch);
        sb.push_back('{ch: ch, wr: 1'b0, rdata: mem(a)});
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            seen = (bus.done_o != 3'b000);
        end
        chk("rd_timeout", 64'(seen), 64'd1);
        bus.req_i = '0;
        tick();
    endtask

    initial begin
        int got;
        rst            = 1'b1;
        bus.req_i      = '0;
        bus.wen_i      = '0;
        bus.addr_i     = '0;
        bus.wdata_i    = '0;
        bus.ram_busy_i = 1'b0;
        bus.tb_ctrl_i  = 1'b0;
        tick();
        tick();
        chk("rst_done", 64'(bus.done_o), 64'd0);
        chk("rst_busy", 64'(bus.busy_o), 64'd0);
        chk("rst_ren", 64'(bus.ram_ren_o), 64'd0);
        chk("rst_wen", 64'(bus.ram_wen_o), 64'd0);
        chk("rst_addr", 64'(bus.ram_addr_o), 64'd0);
        chk("rst_rdata", 64'(bus.rdata_o), 64'd0);
        rst = 1'b0;
        tick();

        // single read, zero-wait memory
        set_addr(0, 32'h40);
        bus.req_i = 3'b001;
        sb.push_back('{ch: 0, wr: 1'b0, rdata: 32'hDEAD_BEEF});
        tick();
        chk("rd_acc_done", 64'(bus.done_o), 64'd0);
        chk("rd_acc_ren", 64'(bus.ram_ren_o), 64'd1);
        chk("rd_acc_wen", 64'(bus.ram_wen_o), 64'd0);
        chk("rd_acc_addr", 64'(bus.ram_addr_o), 64'h40);
        chk("rd_acc_busy", 64'(bus.busy_o), 64'd1);
        tick();
        chk("rd_lat_done", 64'(bus.done_o), 64'b001);
        chk("rd_resp_ren", 64'(bus.ram_ren_o), 64'd0);
        bus.req_i = '0;
        tick();
        chk("rd_idle_busy", 64'(bus.busy_o), 64'd0);

        // rotation from a fresh pointer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) set_addr(k, 32'h100 + 32'(4*k));
        for (int j = 0; j < 6; j++)
            sb.push_back('{ch: j % 3, wr: 1'b0,
                           rdata: mem(32'h100 + 32'(4*(j % 3)))});
        bus.req_i = 3'b111;
        got = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            tick();
            if (bus.done_o != 3'b000) begin
                got++;
                if (got == 6) bus.req_i = '0;
            end
        end
        chk("rot_grants", 64'(got), 64'd6);
        tick();
        chk("rot_idle", 64'(bus.busy_o), 64'd0);

        // channel 1 write with four wait cycles
        set_addr(1, 32'h200);
        bus.wdata_i[32 +: 32] = 32'hCAFE_F00D;
        bus.wen_i      = 3'b010;
        bus.ram_busy_i = 1'b1;
        bus.req_i      = 3'b010;
        sb.push_back('{ch: 1, wr: 1'b1, rdata: 32'h0});
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("ws_wen", 64'(bus.ram_wen_o), 64'd1);
            chk("ws_ren", 64'(bus.ram_ren_o), 64'd0);
            chk("ws_addr", 64'(bus.ram_addr_o), 64'h200);
            chk("ws_store", 64'(bus.ram_store_o), 64'hCAFE_F00D);
            chk("ws_done", 64'(bus.done_o), 64'd0);
            if (i == 5) bus.ram_busy_i = 1'b0;
        end
        tick();
        chk("ws_done_pulse", 64'(bus.done_o), 64'b010);
        chk("ws_wen_off", 64'(bus.ram_wen_o), 64'd0);
        bus.req_i = '0;
        bus.wen_i = '0;
        tick();

        // testbench takes the memory during a channel 2 read
        set_addr(2, 32'h300);
        set_addr(0, 32'h40);
        bus.ram_busy_i = 1'b1;
        bus.req_i      = 3'b100;
        sb.push_back('{ch: 2, wr: 1'b0, rdata: mem(32'h300)});
        tick();
        chk("tbc_addr", 64'(bus.ram_addr_o), 64'h300);
        bus.tb_ctrl_i = 1'b1;
        bus.req_i     = 3'b101;
        set_addr(2, 32'h304);
        tick();
        chk("tbc_addr_hold", 64'(bus.ram_addr_o), 64'h300);
        bus.ram_busy_i = 1'b0;
        tick();
        chk("tbc_done", 64'(bus.done_o), 64'b100);
        bus.req_i = 3'b001;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("tbc_hold_busy", 64'(bus.busy_o), 64'd0);
            chk("tbc_hold_ren", 64'(bus.ram_ren_o), 64'd0);
        end
        bus.tb_ctrl_i = 1'b0;
        sb.push_back('{ch: 0, wr: 1'b0, rdata: 32'hDEAD_BEEF});
        tick();
        chk("tbc_grant_ren", 64'(bus.ram_ren_o), 64'd1);
        chk("tbc_grant_addr", 64'(bus.ram_addr_o), 64'h40);
        tick();
        chk("tbc_done0", 64'(bus.done_o), 64'b001);
        bus.req_i = '0;
        tick();

        // reset in the second access cycle
        bus.ram_busy_i = 1'b1;
        bus.req_i      = 3'b001;
        tick();
        chk("rma_ren1", 64'(bus.ram_ren_o), 64'd1);
        tick();
        chk("rma_ren2", 64'(bus.ram_ren_o), 64'd1);
        rst       = 1'b1;
        bus.req_i = '0;
        tick();
        chk("rma_done", 64'(bus.done_o), 64'd0);
        chk("rma_busy", 64'(bus.busy_o), 64'd0);
        chk("rma_ren", 64'(bus.ram_ren_o), 64'd0);
        chk("rma_wen", 64'(bus.ram_wen_o), 64'd0);
        chk("rma_addr", 64'(bus.ram_addr_o), 64'd0);
        rst            = 1'b0;
        bus.ram_busy_i = 1'b0;
        tick();
        chk("rma_no_done", 64'(bus.done_o), 64'd0);

        // three back-to-back grants to channel 0
        for (int i = 0; i < 3; i++) do_read(0, 32'h40);
`ifdef ARB_STATS_EN
        chk("cnt_after3", 64'(bus.grant_cnt_o), 64'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("cnt_rst", 64'(bus.grant_cnt_o), 64'd0);
`endif
        tick();
        chk("sb_drain", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
